// File: rtl/gpio_scan_pkg.sv
// rtl/gpio_scan_pkg.sv - shared types for the GPIO scan pattern generator
package gpio_scan_pkg;

    typedef enum logic [1:0] {
        MODE_WALK1      = 2'd0,
        MODE_WALK0      = 2'd1,
        MODE_TOGGLE_ALL = 2'd2,
        MODE_CHECKER    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/gpio_pattern_decode.sv
// rtl/gpio_pattern_decode.sv - combinational map from (index, mode) to pin pattern
module gpio_pattern_decode
    import gpio_scan_pkg::*;
#(
    parameter int NUM_PINS = 48,
    parameter int IDX_W    = $clog2(NUM_PINS)
) (
    input  logic [IDX_W-1:0]    index,
    input  mode_t               mode,
    output logic [NUM_PINS-1:0] pattern
);

    always_comb begin
        pattern = '0;
        for (int k = 0; k < NUM_PINS; k++) begin
            unique case (mode)
                MODE_WALK1:      pattern[k] = (k == int'(index));
                MODE_WALK0:      pattern[k] = (k != int'(index));
                MODE_TOGGLE_ALL: pattern[k] = index[0];
                MODE_CHECKER:    pattern[k] = ((k % 2) != 0) ^ index[0];
            endcase
        end
    end

endmodule

// File: rtl/gpio_scan_gen.sv
// rtl/gpio_scan_gen.sv - GPIO scan generator: IDLE/RUN/PAUSE FSM with dwell timing
module gpio_scan_gen
    import gpio_scan_pkg::*;
#(
    parameter int NUM_PINS   = 48,
    parameter int DWELL_BITS = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic                         step_i,
    input  logic [1:0]                   mode_i,
    input  logic [DWELL_BITS-1:0]        dwell_i,
    output logic [NUM_PINS-1:0]          pins_o,
    output logic [$clog2(NUM_PINS)-1:0]  index_o,
    output logic                         wrap_o,
    output logic                         busy_o
);

    localparam int IDX_W = $clog2(NUM_PINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PINS - 1);

    state_t                state, state_n;
    mode_t                 mode_q, mode_n;
    logic [IDX_W-1:0]      index, index_n;
    logic [DWELL_BITS-1:0] dwell_cnt, dwell_n, dwell_load;
    logic                  advance, wrap_n;
    logic [NUM_PINS-1:0]   pattern, pins_n;

    // Counter holds remaining cycles minus one, so dwell 0 and 1 both give one-cycle steps
    assign dwell_load = (dwell_i == '0) ? '0 : dwell_i - DWELL_BITS'(1);

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        index_n = index;
        dwell_n = dwell_cnt;
        advance = 1'b0;
        if (clear_i) begin
            state_n = ST_IDLE;
            index_n = '0;
            dwell_n = '0;
        end else begin
            case (state)
                ST_IDLE: if (enable_i) begin
                    state_n = ST_RUN;
                    mode_n  = mode_t'(mode_i);
                    index_n = '0;
                    dwell_n = dwell_load;
                end
                ST_RUN: if (!enable_i) begin
                    state_n = ST_PAUSE;
                end else if (dwell_cnt == '0) begin
                    advance = 1'b1;
                    dwell_n = dwell_load;
                end else begin
                    dwell_n = dwell_cnt - DWELL_BITS'(1);
                end
                ST_PAUSE: if (enable_i) begin
                    state_n = ST_RUN;
                    dwell_n = dwell_load;
                end else if (step_i) begin
                    advance = 1'b1;
                end
                default: begin
                    state_n = ST_IDLE;
                    index_n = '0;
                end
            endcase
        end
        if (advance) index_n = (index == LAST_IDX) ? '0 : index + IDX_W'(1);
        wrap_n = advance && (index == LAST_IDX);
    end

    // Decoding the next index lets pins and index change on the same edge
    gpio_pattern_decode #(
        .NUM_PINS (NUM_PINS),
        .IDX_W    (IDX_W)
    ) u_decode (
        .index   (index_n),
        .mode    (mode_n),
        .pattern (pattern)
    );

    assign pins_n = (state_n == ST_IDLE) ? '0 : pattern;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_WALK1;
            index     <= '0;
            dwell_cnt <= '0;
            pins_o    <= '0;
            wrap_o    <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            index     <= index_n;
            dwell_cnt <= dwell_n;
            pins_o    <= pins_n;
            wrap_o    <= wrap_n;
        end
    end

    assign index_o = index;
    assign busy_o  = (state != ST_IDLE);

endmodule
